// File: rtl/qam_pkg.sv
// Shared encodings for the QAM symbol path.
package qam_pkg;

  localparam logic MODE_HOLD   = 1'b0;
  localparam logic MODE_ZSTUFF = 1'b1;

  localparam int unsigned UCNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStarved
  } state_e;

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry FIFO holding input symbols ahead of the upsampler.
module sym_fifo2 #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] rd_data_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push, do_pop;

  // Guard against pushing when full or popping when empty.
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      if (do_push && !do_pop)      count_q <= count_q + 2'd1;
      else if (!do_push && do_pop) count_q <= count_q - 2'd1;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/symbol_upsampler.sv
// Expands each accepted multi-lane symbol into fac_l output samples, either held or
// zero-stuffed, on the smp_en timebase.
module symbol_upsampler
  import qam_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FACTOR_MAX = 16,
  parameter int unsigned FW         = $clog2(FACTOR_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      smp_en,
  input  logic                      mode,
  input  logic [FW-1:0]             factor,
  input  logic [CHANNELS*WIDTH-1:0] sym_data,
  input  logic                      sym_valid,
  output logic                      sym_ready,
  output logic [CHANNELS*WIDTH-1:0] smp_data,
  output logic                      smp_valid,
  output logic                      smp_sym_start,
  output logic                      underrun,
  output logic [UCNT_W-1:0]         underrun_cnt
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  state_e            state_q, state_d;
  logic [FW-1:0]     phase_q, phase_d;
  logic [FW-1:0]     fac_q, fac_d;
  logic              mode_q, mode_d;
  logic [DW-1:0]     cur_q, cur_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q;
  logic              start_q, start_d;
  logic              urun_q, urun_d;
  logic [UCNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]     head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              pop, load;
  logic [FW-1:0]     fac_eff;

  // Ready depends on FIFO occupancy only, never on smp_en.
  assign sym_ready  = (fifo_count < 2'd2);
  assign fifo_empty = (fifo_count == 2'd0);

  sym_fifo2 #(
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (sym_valid && sym_ready),
    .wr_data_i (sym_data),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (fifo_count)
  );

  // Effective factor: 0 behaves as 1, oversize values clamp to FACTOR_MAX.
  always_comb begin
    if (factor == '0)                    fac_eff = FW'(1);
    else if (factor > FW'(FACTOR_MAX))   fac_eff = FW'(FACTOR_MAX);
    else                                 fac_eff = factor;
  end

  // FSM, phase counter and next output sample, all advancing only on smp_en.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fac_d   = fac_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    data_d  = data_q;
    start_d = 1'b0;
    urun_d  = 1'b0;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (smp_en) begin
      data_d = '0;
      case (state_q)
        StIdle, StStarved: load = !fifo_empty;
        StRun: begin
          if (phase_q != '0) begin
            data_d  = (mode_q == MODE_HOLD) ? cur_q : '0;
            phase_d = (phase_q == fac_q - FW'(1)) ? '0 : phase_q + FW'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            urun_d  = 1'b1;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + UCNT_W'(1);
            state_d = StStarved;
          end
        end
        default: state_d = StIdle;
      endcase
      if (load) begin
        pop     = 1'b1;
        cur_d   = head;
        fac_d   = fac_eff;
        mode_d  = mode;
        phase_d = (fac_eff == FW'(1)) ? '0 : FW'(1);
        data_d  = head;
        start_d = 1'b1;
        state_d = StRun;
      end
    end
  end

  // State and registered outputs; smp_data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      fac_q   <= FW'(1);
      mode_q  <= MODE_HOLD;
      cur_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      urun_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fac_q   <= fac_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      data_q  <= data_d;
      valid_q <= smp_en;
      start_q <= start_d;
      urun_q  <= urun_d;
      cnt_q   <= cnt_d;
    end
  end

  assign smp_data      = data_q;
  assign smp_valid     = valid_q;
  assign smp_sym_start = start_q;
  assign underrun      = urun_q;
  assign underrun_cnt  = cnt_q;

endmodule

// File: tb/tb_symbol_upsampler.sv
// Scoreboard bench: expected samples are queued with stimulus, checked on smp_valid.
module tb_symbol_upsampler;

  localparam int unsigned FW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_en = 1'b0;
  logic        mode = 1'b0;
  logic [FW-1:0] factor = FW'(1);
  logic [15:0] sym_data = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_sym_start;
  logic        underrun;
  logic [15:0] underrun_cnt;

  symbol_upsampler #(
    .WIDTH      (8),
    .CHANNELS   (2),
    .FACTOR_MAX (16),
    .FW         (FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .smp_en        (smp_en),
    .mode          (mode),
    .factor        (factor),
    .sym_data      (sym_data),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .smp_data      (smp_data),
    .smp_valid     (smp_valid),
    .smp_sym_start (smp_sym_start),
    .underrun      (underrun),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        start;
    logic        urun;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic en_prev = 1'b0;
  logic mon_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [15:0] d, input logic s, input logic u);
    exp_t e;
    e.data  = d;
    e.start = s;
    e.urun  = u;
    exp_q.push_back(e);
  endtask

  // smp_valid must follow smp_en by exactly one clock.
  always @(posedge clk) en_prev <= smp_en & ~rst;

  always @(negedge clk) begin
    if (mon_on) begin
      check_eq("valid_latency", {31'd0, smp_valid}, {31'd0, en_prev});
      if (smp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("smp_data", {16'd0, smp_data}, {16'd0, e.data});
          check_eq("sym_start", {31'd0, smp_sym_start}, {31'd0, e.start});
          check_eq("underrun", {31'd0, underrun}, {31'd0, e.urun});
        end
      end
    end
  end

  task automatic push_sym(input logic [15:0] d);
    sym_data  = d;
    sym_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (sym_ready) begin
        step();
        sym_valid = 1'b0;
        return;
      end
      step();
    end
    check_eq("push_timeout", {31'd0, sym_ready}, 32'd1);
    sym_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      smp_en = 1'b1;
      step();
      smp_en = 1'b0;
      for (int j = 1; j < period; j++) step();
    end
    smp_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check_eq(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smp_en = 1'b0;
    sym_valid = 1'b0;
    step();
    check_eq("rst_data", {16'd0, smp_data}, 32'd0);
    check_eq("rst_flags", {29'd0, smp_valid, smp_sym_start, underrun}, 32'd0);
    check_eq("rst_cnt", {16'd0, underrun_cnt}, 32'd0);
    check_eq("rst_ready", {31'd0, sym_ready}, 32'd1);
    rst = 1'b0;
  endtask

  task automatic stream8(input logic [FW-1:0] fac);
    int ready_low;
    do_reset();
    mode = 1'b0;
    factor = fac;
    ready_low = 0;
    exp_push(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) exp_push(16'hA000 | 16'(i), 1'b1, 1'b0);
    fork
      begin
        for (int i = 0; i < 8; i++) push_sym(16'hA000 | 16'(i));
      end
      begin
        smp_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
          if (!sym_ready) ready_low++;
          step();
        end
        smp_en = 1'b0;
      end
    join
    wait_drain("stream_drain");
    check_eq("stream_ready_low", ready_low, 32'd0);
    check_eq("stream_cnt", {16'd0, underrun_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step();
    mon_on = 1'b1;
    do_reset();

    // Hold, factor 4, two back-to-back symbols.
    mode = 1'b0;
    factor = FW'(4);
    push_sym(16'h1122);
    push_sym(16'h3344);
    exp_push(16'h1122, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) exp_push(16'h1122, 1'b0, 1'b0);
    exp_push(16'h3344, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) exp_push(16'h3344, 1'b0, 1'b0);
    run_ticks(8, 1);
    wait_drain("hold_drain");
    check_eq("hold_cnt", {16'd0, underrun_cnt}, 32'd0);

    // Zero-stuff, factor 3, smp_en every second cycle.
    do_reset();
    mode = 1'b1;
    factor = FW'(3);
    push_sym(16'h7F80);
    exp_push(16'h7F80, 1'b1, 1'b0);
    exp_push(16'h0000, 1'b0, 1'b0);
    exp_push(16'h0000, 1'b0, 1'b0);
    run_ticks(3, 2);
    wait_drain("zstuff_drain");

    // Full-rate streaming with factor 1, then factor 0 treated as 1.
    stream8(FW'(1));
    stream8(FW'(0));

    // Starvation and recovery.
    do_reset();
    mode = 1'b0;
    factor = FW'(2);
    push_sym(16'h5A5A);
    exp_push(16'h5A5A, 1'b1, 1'b0);
    exp_push(16'h5A5A, 1'b0, 1'b0);
    exp_push(16'h0000, 1'b0, 1'b1);
    exp_push(16'h0000, 1'b0, 1'b0);
    exp_push(16'h0000, 1'b0, 1'b0);
    run_ticks(5, 1);
    wait_drain("starve_drain");
    check_eq("starve_cnt", {16'd0, underrun_cnt}, 32'd1);
    push_sym(16'hC3C3);
    exp_push(16'hC3C3, 1'b1, 1'b0);
    exp_push(16'hC3C3, 1'b0, 1'b0);
    run_ticks(2, 1);
    wait_drain("resume_drain");
    check_eq("resume_cnt", {16'd0, underrun_cnt}, 32'd1);

    // Factor change mid-symbol only affects the next symbol.
    do_reset();
    mode = 1'b0;
    factor = FW'(4);
    push_sym(16'h0A0B);
    push_sym(16'h0C0D);
    exp_push(16'h0A0B, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) exp_push(16'h0A0B, 1'b0, 1'b0);
    exp_push(16'h0C0D, 1'b1, 1'b0);
    exp_push(16'h0C0D, 1'b0, 1'b0);
    run_ticks(1, 1);
    factor = FW'(2);
    run_ticks(5, 1);
    wait_drain("facchg_drain");

    // Factor 20 clamps to 16: sixteen samples, then underrun.
    do_reset();
    factor = FW'(20);
    push_sym(16'hBEEF);
    exp_push(16'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) exp_push(16'hBEEF, 1'b0, 1'b0);
    exp_push(16'h0000, 1'b0, 1'b1);
    run_ticks(17, 1);
    wait_drain("clamp_drain");
    check_eq("clamp_cnt", {16'd0, underrun_cnt}, 32'd1);

    // Reset mid-symbol with two symbols buffered discards everything.
    do_reset();
    factor = FW'(4);
    push_sym(16'h1111);
    push_sym(16'h2222);
    exp_push(16'h1111, 1'b1, 1'b0);
    exp_push(16'h1111, 1'b0, 1'b0);
    run_ticks(1, 1);
    push_sym(16'h3333);
    check_eq("full_ready", {31'd0, sym_ready}, 32'd0);
    run_ticks(1, 1);
    wait_drain("prerst_drain");
    do_reset();
    exp_push(16'h0000, 1'b0, 1'b0);
    run_ticks(1, 1);
    wait_drain("postrst_drain");
    check_eq("postrst_cnt", {16'd0, underrun_cnt}, 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/symbol_upsampler.md
Name: symbol_upsampler

Overview:
- Parametrised successor to the single-channel sample inserter: takes QAM symbols over a valid/ready handshake and expands each into FACTOR output samples on a sample-rate enable.
- Output mode is selectable: hold (zero-order upsampling) or zero-stuff (impulse train).
- Supports CHANNELS lanes (I/Q) sharing one timebase.
- Sits between the symbol mapper and the pulse-shaping FIR.

Parameters:
- WIDTH, 8, bits per channel sample (two's complement).
- CHANNELS, 2, number of lanes packed in the data buses (lane 0 = LSBs).
- FACTOR_MAX, 16, maximum upsampling factor; must be at least 1.
- FW, $clog2(FACTOR_MAX+1), width of the factor port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- smp_en  in  1  output sample-rate tick; one output sample per tick
- mode  in  1  0 = hold, 1 = zero-stuff
- factor  in  FW  samples per symbol; 0 is treated as 1, values above FACTOR_MAX are clamped to FACTOR_MAX
- sym_data  in  CHANNELS*WIDTH  input symbol
- sym_valid  in  1  sym_data is valid
- sym_ready  out  1  symbol accepted on a cycle with sym_valid & sym_ready
- smp_data  out  CHANNELS*WIDTH  output sample
- smp_valid  out  1  one-cycle pulse, registered, one cycle after each smp_en
- smp_sym_start  out  1  qualifies smp_valid; marks phase 0 of a real symbol
- underrun  out  1  one-cycle pulse alongside smp_valid when a symbol was due but the buffer was empty
- underrun_cnt  out  16  saturating count of underruns

Behaviour:
- Reset values: all outputs 0; state IDLE; phase 0; buffer empty; underrun_cnt 0. A reset mid-symbol drops the current symbol and any buffered symbols; no partial output follows.
- Input buffer: 2-entry FIFO.
  - sym_ready = (count < 2), derived from registers only; there is no combinational path from smp_en.
  - Push and pop in the same cycle are allowed and leave count unchanged.
  - Sustains full rate with FACTOR = 1 and smp_en held high.
- Phase counter runs 0..fac_l-1 and advances only on smp_en.
  - fac_l (the effective factor) and mode_l (the effective mode) are latched only when a symbol is loaded.
  - Changes to factor or mode therefore take effect on a symbol boundary, never mid-symbol.
- FSM states: IDLE, RUN, STARVED. The following applies on every smp_en tick.
  - IDLE or STARVED, buffer non-empty: pop into cur; latch fac_l and mode_l; phase <= 1, or 0 if fac_l = 1; output cur data with smp_sym_start = 1; go to RUN.
  - IDLE, buffer empty: output zeros, smp_sym_start = 0, no underrun.
  - STARVED, buffer empty: output zeros; underrun stays at 0 (the underrun pulse fires once, on entry to STARVED).
  - RUN, phase != 0: output cur data if mode_l = 0, otherwise zeros. smp_sym_start = 0. Phase increments and wraps to 0 after fac_l-1.
  - RUN, phase = 0, buffer non-empty: load the next symbol exactly as from IDLE.
  - RUN, phase = 0, buffer empty: output zeros; underrun = 1; underrun_cnt += 1, saturating at 0xFFFF; go to STARVED.
- Latency: a symbol present in the buffer when smp_en rises appears on smp_data at the next clock edge, with smp_valid = 1.
- smp_data holds its last value between valid pulses. Consumers must sample only on smp_valid.
- Arithmetic: no sample arithmetic; data passes bit-exact. Zero samples are all-zero per lane.

Decomposition:
- Shared package qam_pkg:
  - mode encodings MODE_HOLD = 0 and MODE_ZSTUFF = 1
  - state encodings
  - counter width constant UCNT_W = 16
- One sub-module, sym_fifo2: 2-entry, WIDTH*CHANNELS-bit FIFO with sync active-high reset and count output.
- Phase, FSM and output logic stay in the top level.

Test Plan:
- Hold mode, factor 4, smp_en every cycle, symbols 0x11_22 then 0x33_44 back-to-back -> smp_data = 0x1122 ×4, then 0x3344 ×4; smp_sym_start on samples 1 and 5; no underrun.
- Zero-stuff mode, factor 3, smp_en every 2nd cycle, symbol 0x7F_80 -> valid outputs 0x7F80, 0x0000, 0x0000, each one cycle after smp_en.
- Factor 1, smp_en continuous, 8 symbols 0..7 streamed with sym_valid held -> 8 consecutive distinct outputs with sym_ready never low while the FIFO drains; factor 0 applied instead gives identical results.
- Starvation: factor 2, one symbol then sym_valid low -> after 2 samples, one underrun pulse, underrun_cnt = 1, zeros thereafter; a new symbol then resumes with smp_sym_start = 1 and no further count increment.
- Factor change mid-symbol: factor 4 → 2 applied at phase 1 -> current symbol still yields 4 samples; the next yields 2. factor = 20 is clamped to 16.
- rst asserted at phase 2 with 2 symbols buffered -> next cycle all outputs 0 and sym_ready = 1; after release, the first tick outputs zeros (IDLE), not the stale symbols.
